// File: rtl/billiard_pkg.sv
// Shared types for the billiard game logic: hole ids and the scorer's state encoding.
package billiard_pkg;

  typedef logic [2:0] hole_t;

  // No previous target yet; never matches a legal hole id.
  localparam hole_t HOLE_NONE = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    ARMED = 3'd4,
    FLASH = 3'd5,
    OVER  = 3'd6
  } scorer_state_t;

endpackage

// File: rtl/pulse_divider.sv
// Emits a one-cycle tick on every CYCLES-th consecutive enabled cycle.
// The count restarts whenever en drops.
module pulse_divider #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles, wrapping on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (!en) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

  // Decoded from the count so the tick falls inside the CYCLES-th enabled cycle.
  assign tick = en && (count_r == LAST);

endmodule

// File: rtl/target_hole_scorer.sv
// Picks a target pocket from the random selector, judges each shot against
// the table's pocket events and keeps score and balls-left until the game ends.
module target_hole_scorer
  import billiard_pkg::*;
#(
  parameter int NUM_HOLES    = 6,
  parameter int NUM_BALLS    = 15,
  parameter int SCORE_W      = 8,
  parameter int HIT_POINTS   = 3,
  parameter int CUE_PENALTY  = 2,
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int MAX_REROLL   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         hole_rand,
  output logic               new_target_req,
  input  logic               pocket_valid,
  input  logic [2:0]         pocket_hole,
  input  logic               cue_pocketed,
  input  logic               shot_done,
  output logic [2:0]         target_hole,
  output logic               target_valid,
  output logic               target_blink,
  output logic               hit_flash,
  output logic               miss_flash,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         balls_left,
  output logic               game_over
);

  localparam int RR_W  = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;
  localparam int SUM_W = SCORE_W + 8;

  localparam hole_t            NUM_HOLES_H = hole_t'(NUM_HOLES);
  localparam logic [RR_W-1:0]  MAX_RR      = RR_W'(MAX_REROLL);
  localparam logic [4:0]       BALLS_INIT  = 5'(NUM_BALLS);
  localparam logic [SUM_W-1:0] SCORE_MAX   = {{8{1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [SUM_W-1:0] HIT_PTS     = SUM_W'(HIT_POINTS);
  localparam logic [SUM_W-1:0] PENALTY     = SUM_W'(CUE_PENALTY);

  scorer_state_t      state_r, state_next_s;
  hole_t              target_r, prev_target_r, hole_pick_s;
  logic [RR_W-1:0]    reroll_r;
  logic [2:0]         hits_r, hits_eff_s;
  logic               cue_foul_r, foul_eff_s;
  logic [SCORE_W-1:0] score_r, score_shot_s;
  logic [4:0]         balls_r, balls_eff_s;
  logic [SUM_W-1:0]   sum_s, sat_s;
  logic               req_r, valid_r, blink_r, hit_flash_r, miss_flash_r, over_r;
  logic               hole_illegal_s, reroll_ok_s;
  logic               blink_en_s, flash_en_s, blink_tick_s, flash_tick_s;

  assign blink_en_s = (state_r == ARMED);
  assign flash_en_s = (state_r == FLASH);

  pulse_divider #(.CYCLES(BLINK_CYCLES)) u_blink_div (
    .clk   (clk),
    .reset (reset),
    .en    (blink_en_s),
    .tick  (blink_tick_s)
  );

  pulse_divider #(.CYCLES(FLASH_CYCLES)) u_flash_div (
    .clk   (clk),
    .reset (reset),
    .en    (flash_en_s),
    .tick  (flash_tick_s)
  );

  // Judge the selector's offer: illegal or repeated ids are re-requested while rerolls remain.
  always_comb begin
    hole_illegal_s = (hole_rand >= NUM_HOLES_H);
    reroll_ok_s    = (hole_illegal_s || (hole_rand == prev_target_r)) && (reroll_r < MAX_RR);
    if (hole_illegal_s) begin
      hole_pick_s = hole_t'(hole_rand % NUM_HOLES_H);
    end else begin
      hole_pick_s = hole_rand;
    end
  end

  // Fold this cycle's pocket events in first, then price the shot.
  always_comb begin
    if (pocket_valid && (pocket_hole == target_r) && (hits_r != 3'd7)) begin
      hits_eff_s = hits_r + 3'd1;
    end else begin
      hits_eff_s = hits_r;
    end
    if (pocket_valid && (balls_r != 5'd0)) begin
      balls_eff_s = balls_r - 5'd1;
    end else begin
      balls_eff_s = balls_r;
    end
    foul_eff_s = cue_foul_r || cue_pocketed;
    sum_s = {{8{1'b0}}, score_r} + (HIT_PTS * {{(SUM_W-3){1'b0}}, hits_eff_s});
    if (sum_s > SCORE_MAX) begin
      sat_s = SCORE_MAX;
    end else begin
      sat_s = sum_s;
    end
    if (!foul_eff_s) begin
      score_shot_s = sat_s[SCORE_W-1:0];
    end else if (sat_s >= PENALTY) begin
      score_shot_s = SCORE_W'(sat_s - PENALTY);
    end else begin
      score_shot_s = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, OVER: begin
        if (start) begin
          state_next_s = REQ;
        end else begin
          state_next_s = state_r;
        end
      end
      REQ:   state_next_s = WAIT;
      WAIT:  state_next_s = LATCH;
      LATCH: begin
        if (reroll_ok_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = ARMED;
        end
      end
      ARMED: begin
        if (shot_done) begin
          state_next_s = FLASH;
        end else begin
          state_next_s = ARMED;
        end
      end
      FLASH: begin
        if (!flash_tick_s) begin
          state_next_s = FLASH;
        end else if (balls_r == 5'd0) begin
          state_next_s = OVER;
        end else if (hit_flash_r) begin
          state_next_s = REQ;
        end else begin
          state_next_s = ARMED;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Game datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r      <= 3'd0;
      prev_target_r <= HOLE_NONE;
      reroll_r      <= '0;
      hits_r        <= 3'd0;
      cue_foul_r    <= 1'b0;
      score_r       <= '0;
      balls_r       <= BALLS_INIT;
      req_r         <= 1'b0;
      valid_r       <= 1'b0;
      blink_r       <= 1'b0;
      hit_flash_r   <= 1'b0;
      miss_flash_r  <= 1'b0;
      over_r        <= 1'b0;
    end else begin
      req_r   <= (state_next_s == REQ);
      valid_r <= (state_next_s == ARMED);
      over_r  <= (state_next_s == OVER);
      if (state_next_s != ARMED) begin
        blink_r <= 1'b0;
      end else if (blink_tick_s) begin
        blink_r <= ~blink_r;
      end
      case (state_r)
        IDLE, OVER: begin
          if (start) begin
            score_r    <= '0;
            balls_r    <= BALLS_INIT;
            hits_r     <= 3'd0;
            cue_foul_r <= 1'b0;
          end
        end
        LATCH: begin
          if (reroll_ok_s) begin
            reroll_r <= reroll_r + 1'b1;
          end else begin
            // Remember the hole actually used so a forced pick is not repeated next time.
            target_r      <= hole_pick_s;
            prev_target_r <= hole_pick_s;
            reroll_r      <= '0;
          end
        end
        ARMED: begin
          balls_r <= balls_eff_s;
          if (shot_done) begin
            score_r      <= score_shot_s;
            hits_r       <= 3'd0;
            cue_foul_r   <= 1'b0;
            hit_flash_r  <= (hits_eff_s != 3'd0);
            miss_flash_r <= (hits_eff_s == 3'd0);
          end else begin
            hits_r     <= hits_eff_s;
            cue_foul_r <= foul_eff_s;
          end
        end
        FLASH: begin
          if (flash_tick_s) begin
            hit_flash_r  <= 1'b0;
            miss_flash_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign new_target_req = req_r;
  assign target_hole    = target_r;
  assign target_valid   = valid_r;
  assign target_blink   = blink_r;
  assign hit_flash      = hit_flash_r;
  assign miss_flash     = miss_flash_r;
  assign score          = score_r;
  assign balls_left     = balls_r;
  assign game_over      = over_r;

endmodule

// File: tb/tb_target_hole_scorer.sv
// Directed bench: cycle-accurate vector table for a full game flow, plus
// hand sequences for reset-in-flight and request-to-armed latency.
module tb_target_hole_scorer;

  logic       clk = 1'b0;
  logic       reset, start, pocket_valid, cue_pocketed, shot_done;
  logic [2:0] hole_rand, pocket_hole;
  logic       new_target_req, target_valid, target_blink, hit_flash, miss_flash, game_over;
  logic [2:0] target_hole;
  logic [3:0] score;
  logic [4:0] balls_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  target_hole_scorer #(
    .NUM_HOLES(6), .NUM_BALLS(3), .SCORE_W(4), .HIT_POINTS(3), .CUE_PENALTY(2),
    .FLASH_CYCLES(8), .BLINK_CYCLES(4), .MAX_REROLL(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hole_rand(hole_rand),
    .new_target_req(new_target_req), .pocket_valid(pocket_valid), .pocket_hole(pocket_hole),
    .cue_pocketed(cue_pocketed), .shot_done(shot_done), .target_hole(target_hole),
    .target_valid(target_valid), .target_blink(target_blink), .hit_flash(hit_flash),
    .miss_flash(miss_flash), .score(score), .balls_left(balls_left), .game_over(game_over)
  );

  // {req, valid, hole, blink, hit, miss, score, balls, over}
  logic [17:0] obs;
  assign obs = {new_target_req, target_valid, target_hole, target_blink, hit_flash,
                miss_flash, score, balls_left, game_over};

  typedef struct {
    logic        st;
    logic [2:0]  hr;
    logic        pv;
    logic [2:0]  ph;
    logic        cue;
    logic        sd;
    int          n;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] pack(int req, int tv, int th, int bk, int hf, int mf,
                                       int sc, int bl, int go);
    return {1'(req), 1'(tv), 3'(th), 1'(bk), 1'(hf), 1'(mf), 4'(sc), 5'(bl), 1'(go)};
  endfunction

  function automatic string fmt(logic [17:0] v);
    return $sformatf("req=%0b valid=%0b hole=%0d blink=%0b hit=%0b miss=%0b score=%0d balls=%0d over=%0b",
                     v[17], v[16], v[15:13], v[12], v[11], v[10], v[9:6], v[5:1], v[0]);
  endfunction

  task automatic add(int st, int hr, int pv, int ph, int cue, int sd, int n,
                     int req, int tv, int th, int bk, int hf, int mf, int sc, int bl, int go);
    vec_t v;
    v.st = 1'(st); v.hr = 3'(hr); v.pv = 1'(pv); v.ph = 3'(ph);
    v.cue = 1'(cue); v.sd = 1'(sd); v.n = n;
    v.exp = pack(req, tv, th, bk, hf, mf, sc, bl, go);
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(obs), fmt(exp));
    end
  endtask

  task automatic drive(logic st, logic [2:0] hr, logic pv, logic [2:0] ph, logic cue, logic sd);
    start = st; hole_rand = hr; pocket_valid = pv; pocket_hole = ph;
    cue_pocketed = cue; shot_done = sd;
  endtask

  initial begin
    logic [17:0] rst_vals;
    int k;
    rst_vals = pack(0, 0, 0, 0, 0, 0, 0, 3, 0);

    // Game 1: first target (no reroll), blink, hit, reroll on illegal id
    add(1,5,0,0,0,0,1, 1,0,0,0,0,0,0,3,0);
    add(0,5,0,0,0,0,2, 0,0,0,0,0,0,0,3,0);
    add(0,5,0,0,0,0,1, 0,1,5,0,0,0,0,3,0);
    add(0,5,0,0,0,0,3, 0,1,5,0,0,0,0,3,0);
    add(0,5,0,0,0,0,2, 0,1,5,1,0,0,0,3,0);
    add(0,5,1,5,0,0,1, 0,1,5,1,0,0,0,2,0);
    add(0,5,0,0,0,1,1, 0,0,5,0,1,0,3,2,0);
    add(0,6,0,0,0,0,7, 0,0,5,0,1,0,3,2,0);
    add(0,6,0,0,0,0,1, 1,0,5,0,0,0,3,2,0);
    add(0,6,0,0,0,0,2, 0,0,5,0,0,0,3,2,0);
    add(0,6,0,0,0,0,1, 1,0,5,0,0,0,3,2,0);
    add(0,2,0,0,0,0,2, 0,0,5,0,0,0,3,2,0);
    add(0,2,0,0,0,0,1, 0,1,2,0,0,0,3,2,0);
    // Foul-only shot, then foul with a wrong pocket: score floors at 0, same target kept
    add(0,2,0,0,1,1,1, 0,0,2,0,0,1,1,2,0);
    add(0,2,0,0,0,0,7, 0,0,2,0,0,1,1,2,0);
    add(0,2,0,0,0,0,1, 0,1,2,0,0,0,1,2,0);
    add(0,2,1,4,1,1,1, 0,0,2,0,0,1,0,1,0);
    add(0,2,0,0,0,0,7, 0,0,2,0,0,1,0,1,0);
    add(0,2,0,0,0,0,1, 0,1,2,0,0,0,0,1,0);
    // Eight target pockets: balls floor at 0, hits cap at 7, score saturates at 15
    add(0,2,1,2,0,0,3, 0,1,2,0,0,0,0,0,0);
    add(0,2,1,2,0,0,4, 0,1,2,1,0,0,0,0,0);
    add(0,2,1,2,0,0,1, 0,1,2,0,0,0,0,0,0);
    add(0,2,0,0,0,1,1, 0,0,2,0,1,0,15,0,0);
    add(0,2,0,0,0,0,7, 0,0,2,0,1,0,15,0,0);
    add(0,2,0,0,0,0,1, 0,0,2,0,0,0,15,0,1);
    add(0,2,1,2,1,1,2, 0,0,2,0,0,0,15,0,1);
    // Restart from OVER; repeated target accepted after three rerolls
    add(1,2,0,0,0,0,1, 1,0,2,0,0,0,0,3,0);
    for (int r = 0; r < 3; r++) begin
      add(0,2,0,0,0,0,2, 0,0,2,0,0,0,0,3,0);
      add(0,2,0,0,0,0,1, 1,0,2,0,0,0,0,3,0);
    end
    add(0,2,0,0,0,0,2, 0,0,2,0,0,0,0,3,0);
    add(0,2,0,0,0,0,1, 0,1,2,0,0,0,0,3,0);
    // Pocket and shot_done together; start during FLASH ignored; illegal id forced to 7 mod 6
    add(0,7,1,2,0,1,1, 0,0,2,0,1,0,3,2,0);
    add(1,7,0,0,0,0,7, 0,0,2,0,1,0,3,2,0);
    add(0,7,0,0,0,0,1, 1,0,2,0,0,0,3,2,0);
    for (int r = 0; r < 3; r++) begin
      add(0,7,0,0,0,0,2, 0,0,2,0,0,0,3,2,0);
      add(0,7,0,0,0,0,1, 1,0,2,0,0,0,3,2,0);
    end
    add(0,7,0,0,0,0,2, 0,0,2,0,0,0,3,2,0);
    add(0,7,0,0,0,0,1, 0,1,1,0,0,0,3,2,0);

    // Reset dominates a same-cycle start and pocket event
    reset = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("reset", rst_vals);
    end
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc();
    check("idle", rst_vals);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].hr, vecs[i].pv, vecs[i].ph, vecs[i].cue, vecs[i].sd);
      for (int c = 0; c < vecs[i].n; c++) begin
        cyc();
        check($sformatf("vec%0d.%0d", i, c), vecs[i].exp);
      end
    end

    // Reset while flashing
    drive(1'b0, 3'd1, 1'b1, 3'd1, 1'b0, 1'b1);
    cyc();
    check("flash_entry", pack(0, 0, 1, 0, 1, 0, 6, 1, 0));
    drive(1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc();
    reset = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 1'b1);
    cyc();
    check("reset_in_flash", rst_vals);
    reset = 1'b0;
    drive(1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("after_flash_reset", rst_vals);
    end

    // Reset while waiting on the selector
    start = 1'b1;
    cyc();
    check("req_pulse", pack(1, 0, 0, 0, 0, 0, 0, 3, 0));
    start = 1'b0;
    cyc();
    check("wait", rst_vals);
    reset = 1'b1;
    cyc();
    check("reset_in_wait", rst_vals);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("after_wait_reset", rst_vals);
    end

    // Request-to-armed latency, bounded wait
    hole_rand = 3'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (!target_valid && k < 10) begin
      cyc();
      k++;
    end
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL arm_latency: got %0d cycles after request, expected 3", k);
    end
    check("armed_target", pack(0, 1, 3, 0, 0, 0, 0, 3, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
